puf_resp_serializer: RTL and testbench

Captures one response bit from the PUF core each time it signals completion and buffers it in a bit-wide FIFO. Presents the bits one per cycle under a valid/ready handshake to the NIST test stage, which consumes one bit per test-clock cycle. Sits between the PUF mapping core (`done`, `raw_response`, `xor_response`) and the test data input of the NIST block. It decouples PUF evaluation timing from test-block consumption and flags lost bits.

---
 rtl/puf_resp_serializer_if.sv | 22 ++
 rtl/puf_resp_serializer.sv | 153 +++++++++++++++
 tb/tb_puf_resp_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/puf_resp_serializer_if.sv
// Bit-stream bundle: PUF completion/response on one side, valid/ready bit
// handshake toward the NIST test input on the other.
interface puf_resp_serializer_if #(
  parameter int RESPONSE_WIDTH = 6
);
  logic                      done;
  logic [RESPONSE_WIDTH-1:0] raw_response;
  logic                      xor_response;
  logic                      bit_out;
  logic                      bit_valid;
  logic                      bit_ready;

  modport master (
    output done, raw_response, xor_response, bit_ready,
    input  bit_out, bit_valid
  );

  modport slave (
    input  done, raw_response, xor_response, bit_ready,
    output bit_out, bit_valid
  );
endinterface

// File: rtl/puf_resp_serializer.sv
// Captures one PUF response bit per done rising edge into a bit FIFO and streams it out.
// Optional von Neumann debiaser ahead of the FIFO when VON_NEUMANN_EN is defined.
module puf_resp_serializer #(
  parameter int RESPONSE_WIDTH = 6,
  parameter int DEPTH          = 16,
  parameter int CNT_W          = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                use_xor,
  input  logic [2:0]          bit_sel,
  puf_resp_serializer_if.slave bus,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic             done_q;
  logic             cap_evt;
  logic             cap_vld;
  logic             cap_bit;
  logic             raw_sel;
  logic             sel_bit;
  logic             push_req;
  logic             push_bit;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             head_vld;

  // Out-of-range indices fall back to bit 0.
  always_comb begin
    raw_sel = bus.raw_response[0];
    for (int i = 1; i < RESPONSE_WIDTH; i++) begin
      if (int'(bit_sel) == i) raw_sel = bus.raw_response[i];
    end
  end

  assign sel_bit = use_xor ? bus.xor_response : raw_sel;
  assign cap_evt = bus.done && !done_q && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      cap_vld <= 1'b0;
      cap_bit <= 1'b0;
    end else begin
      done_q  <= bus.done;
      cap_vld <= cap_evt;
      if (cap_evt) cap_bit <= sel_bit;
    end
  end

`ifdef VON_NEUMANN_EN
  // state   | meaning
  // VN_EMPTY| no first bit held; next capture becomes vn_first
  // VN_HOLD | vn_first valid; next capture completes the pair
  typedef enum logic {VN_EMPTY, VN_HOLD} vn_state_t;

  vn_state_t vn_state;
  vn_state_t vn_state_nxt;
  logic      vn_first;

  always_ff @(posedge clk) begin
    if (rst) vn_state <= VN_EMPTY;
    else     vn_state <= vn_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                                             vn_first <= 1'b0;
    else if (vn_state == VN_EMPTY && cap_vld && enable) vn_first <= cap_bit;
  end

  always_comb begin
    vn_state_nxt = vn_state;
    if (!enable)      vn_state_nxt = VN_EMPTY;
    else if (cap_vld) vn_state_nxt = (vn_state == VN_EMPTY) ? VN_HOLD : VN_EMPTY;
  end

  // Pair 01 emits 0, pair 10 emits 1: the emitted bit equals the first bit.
  always_comb begin
    push_req = 1'b0;
    push_bit = vn_first;
    if (vn_state == VN_HOLD && cap_vld && enable && (cap_bit != vn_first))
      push_req = 1'b1;
  end
`else
  assign push_req = cap_vld;
  assign push_bit = cap_bit;
`endif

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = bus.bit_valid && bus.bit_ready;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_nxt        = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign cnt_after_pop = count - CNT_W'(pop);
  assign head_vld      = (cnt_after_pop != '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_bit;
  end

  // The output register reads the pre-push array, so a fresh bit shows at
  // the head one cycle after it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.bit_valid <= 1'b0;
      bus.bit_out   <= 1'b0;
      overflow      <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr        <= rd_nxt;
      count         <= count_nxt;
      bus.bit_valid <= head_vld;
      bus.bit_out   <= head_vld ? mem[rd_nxt] : 1'b0;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_puf_resp_serializer.sv
// Directed bench for puf_resp_serializer; debiaser steps run only when VON_NEUMANN_EN is defined.
module tb_puf_resp_serializer;

  localparam int RW    = 6;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             use_xor;
  logic [2:0]       bit_sel;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       drop_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] pat;

  puf_resp_serializer_if #(.RESPONSE_WIDTH(RW)) bus();

  puf_resp_serializer #(
    .RESPONSE_WIDTH(RW),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .use_xor(use_xor),
    .bit_sel(bit_sel),
    .bus(bus),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse(input logic [RW-1:0] raw, input logic xr);
    bus.raw_response = raw;
    bus.xor_response = xr;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    use_xor = 1'b0;
    bit_sel = 3'd1;
    bus.done = 1'b0;
    bus.raw_response = '0;
    bus.xor_response = 1'b0;
    bus.bit_ready = 1'b0;

    // reset and idle
    tick();
    tick();
    chk("rst_bit_out", bus.bit_out, 0);
    chk("rst_bit_valid", bus.bit_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_bit_valid", bus.bit_valid, 0);
    end
    chk("idle_fifo_count", fifo_count, 0);

    // pass-through, raw bit 1
    bus.bit_ready = 1'b1;
    bus.raw_response = 6'b000010;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("pt_a_valid_k", bus.bit_valid, 0);
    tick();
    chk("pt_a_valid_k1", bus.bit_valid, 0);
    chk("pt_a_count_k1", fifo_count, 1);
    tick();
    chk("pt_a_valid_k2", bus.bit_valid, 1);
    chk("pt_a_bit", bus.bit_out, 1);
    bus.raw_response = 6'b000000;
    bus.done = 1'b1;
    tick();
    chk("pt_a_one_cycle", bus.bit_valid, 0);
    bus.done = 1'b0;
    tick();
    chk("pt_b_valid_k1", bus.bit_valid, 0);
    tick();
    chk("pt_b_valid_k2", bus.bit_valid, 1);
    chk("pt_b_bit", bus.bit_out, 0);
    tick();
    chk("pt_b_one_cycle", bus.bit_valid, 0);
    chk("pt_count_end", fifo_count, 0);

    // bit_sel boundaries: 7 falls back to bit 0, 5 is the top bit
    bus.bit_ready = 1'b0;
    bit_sel = 3'd7;
    pulse(6'b111110, 1'b1);
    pulse(6'b000001, 1'b0);
    bit_sel = 3'd5;
    pulse(6'b100000, 1'b0);
    tick();
    chk("sel_count", fifo_count, 3);
    chk("sel7_a_bit", bus.bit_out, 0);
    bus.bit_ready = 1'b1;
    tick();
    chk("sel7_b_bit", bus.bit_out, 1);
    tick();
    chk("sel5_bit", bus.bit_out, 1);
    chk("sel5_valid", bus.bit_valid, 1);
    tick();
    chk("sel_drained", bus.bit_valid, 0);
    bus.bit_ready = 1'b0;

    // fill and overflow
    do_reset();
    use_xor = 1'b1;
    pat = 18'b10_1100_1110_0010_1101;
    for (int i = 0; i < 18; i++) pulse(6'b000000, pat[i]);
    tick();
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    chk("ovf_valid", bus.bit_valid, 1);
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", bus.bit_valid, 1);
      chk("drain_bit", bus.bit_out, pat[i]);
      tick();
    end
    chk("drain_empty", bus.bit_valid, 0);
    chk("drain_count", fifo_count, 0);
    chk("drain_ovf_sticky", overflow, 1);
    bus.bit_ready = 1'b0;

    // full with simultaneous push and pop
    do_reset();
    chk("fp_rst_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) pulse(6'b000000, pat[i]);
    tick();
    chk("fp_full", fifo_count, 16);
    bus.xor_response = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.bit_ready = 1'b1;
    tick();
    bus.bit_ready = 1'b0;
    chk("fp_count", fifo_count, 16);
    chk("fp_ovf", overflow, 0);
    chk("fp_drops", drop_count, 0);
    chk("fp_head", bus.bit_out, pat[1]);

    // level done gives one capture; mid-run reset empties
    do_reset();
    bus.xor_response = 1'b1;
    bus.done = 1'b1;
    repeat (5) tick();
    bus.done = 1'b0;
    repeat (3) tick();
    chk("lvl_count", fifo_count, 1);
    for (int i = 0; i < 4; i++) pulse(6'b000000, 1'b1);
    tick();
    chk("mid_count", fifo_count, 5);
    chk("mid_valid", bus.bit_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", bus.bit_valid, 0);

`ifdef VON_NEUMANN_EN
    // debiaser: pairs 01,11,10,00 -> 0,1
    do_reset();
    pulse(6'b0, 1'b0); pulse(6'b0, 1'b1);
    pulse(6'b0, 1'b1); pulse(6'b0, 1'b1);
    pulse(6'b0, 1'b1); pulse(6'b0, 1'b0);
    pulse(6'b0, 1'b0); pulse(6'b0, 1'b0);
    tick();
    chk("vn_count", fifo_count, 2);
    chk("vn_bit0", bus.bit_out, 0);
    bus.bit_ready = 1'b1;
    tick();
    chk("vn_valid1", bus.bit_valid, 1);
    chk("vn_bit1", bus.bit_out, 1);
    tick();
    chk("vn_empty", bus.bit_valid, 0);
    bus.bit_ready = 1'b0;
    pulse(6'b0, 1'b1);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    pulse(6'b0, 1'b1);
    pulse(6'b0, 1'b0);
    tick();
    chk("vn_en_count", fifo_count, 1);
    chk("vn_en_bit", bus.bit_out, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
